// File: rtl/bresenham_line_ctrl.sv
// Bresenham line sequencer: one relative (dx,dy) line per command, one cell per handshake.
// Optional BRESENHAM_SKIP_ENDPOINT_EN drops the endpoint cell (free-space ray marking).

// Maps a canonical-octant point (x_in=u, y_in=v) back into the real frame.
module flip_indices #(
   parameter int XW = 8,
   parameter int YW = 7
) (
   input  logic [XW-1:0]        x_in,
   input  logic [YW-1:0]        y_in,
   input  logic                 flip_x,
   input  logic                 flip_y,
   input  logic                 flip_identity,
   output logic signed [XW-1:0] x_out,
   output logic signed [YW-1:0] y_out
);
   logic [XW-1:0] a;
   logic [YW-1:0] b;

   // When swapped, u walks the y axis; u never exceeds |dy| so it fits in YW.
   assign a     = flip_identity ? {{(XW-YW){1'b0}}, y_in} : x_in;
   assign b     = flip_identity ? x_in[YW-1:0] : y_in;
   assign x_out = flip_x ? -a : a;
   assign y_out = flip_y ? -b : b;
endmodule

module bresenham_line_ctrl #(
   parameter int XW = 8,
   parameter int YW = 7,
   parameter int EW = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic signed [XW-1:0] dx,
   input  logic signed [YW-1:0] dy,
   output logic                 busy,
   output logic                 cell_valid,
   input  logic                 cell_ready,
   output logic signed [XW-1:0] cell_x,
   output logic signed [YW-1:0] cell_y,
   output logic                 cell_last,
   output logic                 done,
   output logic                 error
);
   typedef enum logic [1:0] {IDLE, SETUP, RUN, FIN} state_t;

   state_t                state, state_n;
   logic signed [XW-1:0]  dx_r;
   logic signed [YW-1:0]  dy_r;
   logic                  flip_x, flip_y, flip_id;
   logic [XW-1:0]         du, dv, u, u_end;
   logic [YW-1:0]         v;
   logic signed [EW-1:0]  err;
   logic                  error_q;

   logic [XW-1:0]         ax, ay_x, du_c, dv_c;
   logic [YW-1:0]         ay;
   logic                  swap_c, bad_cmd, hs;

   // Doubled magnitude, zero-extended into the accumulator width.
   function automatic logic signed [EW-1:0] dbl(input logic [XW-1:0] m);
      return {{(EW-XW-1){1'b0}}, m, 1'b0};
   endfunction

   assign bad_cmd = (dx == {1'b1, {(XW-1){1'b0}}}) || (dy == {1'b1, {(YW-1){1'b0}}});
   assign ax      = dx_r[XW-1] ? -dx_r : dx_r;
   assign ay      = dy_r[YW-1] ? -dy_r : dy_r;
   assign ay_x    = {{(XW-YW){1'b0}}, ay};
   assign swap_c  = ay_x > ax;
   assign du_c    = swap_c ? ay_x : ax;
   assign dv_c    = swap_c ? ax : ay_x;
   assign hs      = cell_valid && cell_ready;

`ifdef BRESENHAM_SKIP_ENDPOINT_EN
   assign u_end = du - 1'b1;
`else
   assign u_end = du;
`endif

   always_comb begin
      state_n    = state;
      busy       = 1'b0;
      cell_valid = 1'b0;
      cell_last  = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE:  if (start && !bad_cmd) state_n = SETUP;
         SETUP: begin
            busy    = 1'b1;
            state_n = RUN;
`ifdef BRESENHAM_SKIP_ENDPOINT_EN
            if (du_c == '0) state_n = FIN;
`endif
         end
         RUN: begin
            busy       = 1'b1;
            cell_valid = 1'b1;
            cell_last  = (u == u_end);
            if (hs && u == u_end) state_n = FIN;
         end
         FIN: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         dx_r    <= '0;
         dy_r    <= '0;
         flip_x  <= 1'b0;
         flip_y  <= 1'b0;
         flip_id <= 1'b0;
         du      <= '0;
         dv      <= '0;
         u       <= '0;
         v       <= '0;
         err     <= '0;
         error_q <= 1'b0;
      end else begin
         state   <= state_n;
         error_q <= (state == IDLE) && start && bad_cmd;
         case (state)
            IDLE: if (start && !bad_cmd) begin
               dx_r <= dx;
               dy_r <= dy;
            end
            SETUP: begin
               flip_x  <= dx_r[XW-1];
               flip_y  <= dy_r[YW-1];
               flip_id <= swap_c;
               du      <= du_c;
               dv      <= dv_c;
               u       <= '0;
               v       <= '0;
               err     <= dbl(dv_c) - $signed({{(EW-XW){1'b0}}, du_c});
            end
            RUN: if (hs && u != u_end) begin
               u <= u + 1'b1;
               if (err > 0) begin
                  v   <= v + 1'b1;
                  err <= err - dbl(du) + dbl(dv);
               end else begin
                  err <= err + dbl(dv);
               end
            end
            default: ;
         endcase
      end
   end

   assign error = error_q;

   flip_indices #(.XW(XW), .YW(YW)) u_flip (
      .x_in          (u),
      .y_in          (v),
      .flip_x        (flip_x),
      .flip_y        (flip_y),
      .flip_identity (flip_id),
      .x_out         (cell_x),
      .y_out         (cell_y)
   );
endmodule

// File: tb/tb_bresenham_line_ctrl.sv
// Directed bench for bresenham_line_ctrl; follows BRESENHAM_SKIP_ENDPOINT_EN if defined.
module tb_bresenham_line_ctrl;
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic signed [7:0] dx = '0;
   logic signed [6:0] dy = '0;
   logic              busy, cell_valid, cell_last, done, error;
   logic              cell_ready = 1'b1;
   logic signed [7:0] cell_x;
   logic signed [6:0] cell_y;

   int passed = 0;
   int total  = 0;
   int exq[$];
   int eyq[$];

   bresenham_line_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dx(dx), .dy(dy),
      .busy(busy), .cell_valid(cell_valid), .cell_ready(cell_ready),
      .cell_x(cell_x), .cell_y(cell_y), .cell_last(cell_last),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Runs one line against exq/eyq (full list incl. endpoint).
   task automatic run_line(input int sdx, input int sdy, input int stall_at, input int poke_at);
      int n;
      n = exq.size();
`ifdef BRESENHAM_SKIP_ENDPOINT_EN
      n = n - 1;
`endif
      dx = 8'(sdx); dy = 7'(sdy); start = 1'b1;
      step();
      start = 1'b0;
      check("setup_busy", int'(busy), 1);
      check("setup_valid", int'(cell_valid), 0);
      step();
      for (int i = 0; i < n; i++) begin
         check($sformatf("cell%0d_valid", i), int'(cell_valid), 1);
         check($sformatf("cell%0d_x", i), int'(cell_x), exq[i]);
         check($sformatf("cell%0d_y", i), int'(cell_y), eyq[i]);
         check($sformatf("cell%0d_last", i), int'(cell_last), (i == n-1) ? 1 : 0);
         if (i == stall_at) begin
            cell_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               step();
               check("stall_valid", int'(cell_valid), 1);
               check("stall_x", int'(cell_x), exq[i]);
               check("stall_y", int'(cell_y), eyq[i]);
               check("stall_done", int'(done), 0);
            end
            cell_ready = 1'b1;
         end
         if (i == poke_at) begin
            start = 1'b1; dx = 8'sd3; dy = 7'sd1;
         end
         step();
         start = 1'b0;
      end
      check("fin_done", int'(done), 1);
      check("fin_busy", int'(busy), 0);
      check("fin_valid", int'(cell_valid), 0);
      step();
      check("idle_done", int'(done), 0);
      check("idle_busy", int'(busy), 0);
   endtask

   initial begin
      #2;
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(cell_valid), 0);
      check("rst_x", int'(cell_x), 0);
      check("rst_y", int'(cell_y), 0);
      check("rst_done", int'(done), 0);
      check("rst_error", int'(error), 0);
      step();
      rst_n = 1'b1;
      step();

      exq = '{0, 1, 2, 3, 4, 5}; eyq = '{0, 0, 1, 1, 2, 2};
      run_line(5, 2, -1, -1);

      exq = '{0, 0, -1, -1, -2, -2}; eyq = '{0, -1, -2, -3, -4, -5};
      run_line(-2, -5, -1, -1);

      exq = '{0}; eyq = '{0};
      run_line(0, 0, -1, -1);

      exq = '{0, 1, 2, 3, 4, 5, 6, 7}; eyq = '{0, 1, 2, 3, 4, 5, 6, 7};
      run_line(7, 7, 3, -1);

      // Illegal command: -2^(XW-1)
      dx = -8'sd128; dy = 7'sd0; start = 1'b1;
      step();
      start = 1'b0;
      check("err_pulse", int'(error), 1);
      check("err_busy", int'(busy), 0);
      check("err_valid", int'(cell_valid), 0);
      step();
      check("err_clear", int'(error), 0);
      check("err_busy2", int'(busy), 0);
      check("err_valid2", int'(cell_valid), 0);

      // Start pulsed mid-line is ignored
      exq = '{0, 1, 2, 3, 4, 5}; eyq = '{0, 0, 1, 1, 2, 2};
      run_line(5, 2, -1, 1);

      // Async reset mid-line at cell 2 of (10,3)
      dx = 8'sd10; dy = 7'sd3; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      check("pre_rst_x", int'(cell_x), 2);
      check("pre_rst_y", int'(cell_y), 1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_valid", int'(cell_valid), 0);
      check("arst_x", int'(cell_x), 0);
      check("arst_y", int'(cell_y), 0);
      check("arst_last", int'(cell_last), 0);
      step();
      check("arst_done", int'(done), 0);
      rst_n = 1'b1;
      step();

      exq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10}; eyq = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3};
      run_line(10, 3, -1, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/bresenham_line_ctrl.md
Name: bresenham_line_ctrl

Overview:
- Sequences one Bresenham line per command. Each line is a relative offset (dx, dy) from a ray origin, and the block emits the traversed grid cells one per handshake.
- Classifies the octant, runs the stepping core in the canonical octant (0 <= minor <= major), and maps each canonical point back to the real frame through an internal flip_indices instance.
- Sits between the scan-ray dispatcher and the occupancy-grid update pipeline.

Parameters:
- XW, 8, width of signed x offset and of the major-axis counter.
- YW, 7, width of signed y offset; must be less than XW.
- EW, 10, width of the signed error accumulator; must be at least XW+2.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; accepted only in IDLE.
- dx  in  XW  signed x offset of the line end relative to origin.
- dy  in  YW  signed y offset of the line end relative to origin.
- busy  out  1  high from the cycle after accept until the return to IDLE.
- cell_valid  out  1  cell_x/cell_y/cell_last hold a cell.
- cell_ready  in  1  downstream accepts a cell when cell_valid && cell_ready.
- cell_x  out  XW  signed relative x of the current cell.
- cell_y  out  YW  signed relative y of the current cell.
- cell_last  out  1  current cell is the final cell of the line.
- done  out  1  one-cycle pulse after the last cell handshake.
- error  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset: state=IDLE. busy, cell_valid, cell_last, done and error are 0. cell_x and cell_y are 0. All internal registers are 0.
- States: IDLE, SETUP, RUN, FIN.
- IDLE:
  - start=1 with dx = -2^(XW-1) or dy = -2^(YW-1): pulse error next cycle and stay in IDLE.
  - Otherwise, latch dx and dy and go to SETUP.
- SETUP (1 cycle):
  - flip_x = dx<0; flip_y = dy<0; ax=|dx|; ay=|dy|.
  - flip_identity = ay>ax. A diagonal (ay==ax) is not swapped.
  - du = flip_identity ? ay : ax; dv = the other magnitude.
  - u=0, v=0, err = 2*dv - du, all computed in EW bits with sign extension.
  - Go to RUN.
- RUN:
  - cell_valid=1. Cell = flip_indices(u, v) with the latched flips; u drives x_in and v drives y_in.
  - cell_last = (u==du).
  - On handshake with u<du:
    - if err>0, then v<=v+1 and err<=err-2*du+2*dv;
    - else err<=err+2*dv;
    - u<=u+1.
  - On handshake with u==du: go to FIN.
  - Without a handshake, u, v, err and all outputs hold stable. Downstream may stall indefinitely.
- FIN: done=1 for one cycle; cell_valid=0; go to IDLE. busy drops in the same cycle as done.
- Latency: accept to first cell_valid is 2 cycles. Sustained rate is 1 cell/cycle with cell_ready held high. A line emits du+1 cells.
- Zero-length line (dx=dy=0): exactly one cell (0,0) with cell_last=1.
- start while busy is ignored, with no queueing.
- rst_n low mid-line aborts immediately to reset values; no done pulse is produced.
- Arithmetic: everything stays inside EW bits, so there is no overflow for any legal du (at most 2^(XW-1)-1).

Optional Feature:
- Macro BRESENHAM_SKIP_ENDPOINT_EN.
- Defined:
  - The endpoint cell (u==du) is never presented. cell_last asserts on the cell with u==du-1.
  - Zero-length line: no cells; the block goes SETUP -> FIN and pulses done.
  - Purpose: free-space ray marking, where the endpoint is handled as an occupied cell elsewhere.
- Undefined: all du+1 cells are emitted as described in Behaviour.

Test Plan:
- dx=5, dy=2, ready=1:
  - cells (0,0),(1,0),(2,1),(3,1),(4,2),(5,2);
  - last on (5,2); done exactly 1 cycle after that handshake; first valid 2 cycles after start.
- dx=-2, dy=-5 (swap, both flips):
  - cells (0,0),(0,-1),(-1,-2),(-1,-3),(-2,-4),(-2,-5);
  - last on (-2,-5).
- dx=0, dy=0: single cell (0,0) with last=1, then done. With the macro defined: zero cells and done 2 cycles after start.
- dx=7, dy=7, cell_ready low for 3 cycles at cell (3,3): outputs hold (3,3) unchanged; the sequence resumes and finishes at (7,7).
- dx=-128: error pulse 1 cycle after start; busy stays 0; no cells. Second case: start pulsed during RUN is ignored and the current line completes unchanged.
- Reset mid-line: rst_n low at cell 2 of dx=10, dy=3 gives all outputs 0 asynchronously; the next command runs correctly from (0,0).
